// File: rtl/uart_pkg.sv
// Shared definitions for the 64-bit RS-232 block link: line levels, frame
// geometry and the state encoding used by the transmit and receive serializers.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int   FRAME_BITS = 10;
    localparam int   DATA_BITS  = 8;
    localparam logic START_LVL  = 1'b0;
    localparam logic STOP_LVL   = 1'b1;
    localparam logic IDLE_LVL   = 1'b1;

    // 50 MHz system clock at 115200 baud.
    localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running bit-period counter; tick marks the last clock of each bit.
// clear restarts the period so the next bit gets its full width.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state is assigned with <= so every flop samples its
    // inputs from the same edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_block_tx.sv
// Block serializer: sends one 8*NUM_BYTES-bit block as back-to-back 8N1
// frames, byte 0 first and LSB first within each byte.
module uart_block_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int NUM_BYTES    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*NUM_BYTES-1:0] data_in,
    input  logic                   tx_start,
    output logic                   tx_out,
    output logic                   busy,
    output logic                   done
);

    // A single-byte block still needs a 1-bit byte counter.
    localparam int            BW        = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [BW-1:0] LAST_BYTE = BW'(NUM_BYTES - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

    uart_state_e            state;
    logic [2:0]             bit_cnt;
    logic [BW-1:0]          byte_cnt;
    logic [8*NUM_BYTES-1:0] shift;
    logic                   tick;
    logic                   accept;

    assign accept = (state == IDLE) && tx_start;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(accept),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx_out   <= IDLE_LVL;
            busy     <= 1'b0;
            done     <= 1'b0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            shift    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_start) begin
                        shift    <= data_in;
                        state    <= START;
                        tx_out   <= START_LVL;
                        busy     <= 1'b1;
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        tx_out <= shift[0];
                        shift  <= shift >> 1;
                        state  <= DATA;
                    end
                end
                DATA: begin
                    // Bit 0 left on the START tick, so only seven more shifts per byte.
                    if (tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            state   <= STOP;
                            tx_out  <= STOP_LVL;
                            bit_cnt <= '0;
                        end else begin
                            tx_out  <= shift[0];
                            shift   <= shift >> 1;
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (byte_cnt != LAST_BYTE) begin
                            byte_cnt <= byte_cnt + BW'(1);
                            state    <= START;
                            tx_out   <= START_LVL;
                        end else begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            byte_cnt <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_block_tx.sv
// Bench for uart_block_tx: a per-cycle line model built from frame rules,
// plus an independent mid-bit decoder, for an 8-byte and a 1-byte instance.
module tb_uart_block_tx;

    localparam int CPB_A = 4;
    localparam int NB_A  = 8;
    localparam int LEN_A = CPB_A * 10 * NB_A;
    localparam int CPB_B = 2;
    localparam int NB_B  = 1;
    localparam int LEN_B = CPB_B * 10 * NB_B;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_start, a_tx, a_busy, a_done;
    logic [63:0] a_data;
    logic        b_start, b_tx, b_busy, b_done;
    logic [7:0]  b_data;

    int errors = 0;
    int checks = 0;
    bit exp_wave[$];

    always #5 clk = ~clk;

    uart_block_tx #(.CLKS_PER_BIT(CPB_A), .NUM_BYTES(NB_A)) dut_a (
        .clk(clk), .rst(rst), .data_in(a_data), .tx_start(a_start),
        .tx_out(a_tx), .busy(a_busy), .done(a_done)
    );

    uart_block_tx #(.CLKS_PER_BIT(CPB_B), .NUM_BYTES(NB_B)) dut_b (
        .clk(clk), .rst(rst), .data_in(b_data), .tx_start(b_start),
        .tx_out(b_tx), .busy(b_busy), .done(b_done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected line level for every cycle of a block, from the 8N1 frame rule.
    function automatic void build_wave(input logic [63:0] blk, input int nb, input int cpb);
        exp_wave.delete();
        for (int f = 0; f < nb; f++) begin
            for (int s = 0; s < 10; s++) begin
                bit lvl;
                if (s == 0)      lvl = 1'b0;
                else if (s == 9) lvl = 1'b1;
                else             lvl = blk[f*8 + s - 1];
                repeat (cpb) exp_wave.push_back(lvl);
            end
        end
    endfunction

    task automatic start_a(input logic [63:0] blk);
        a_data  = blk;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
    endtask

    // Sample k is taken k cycles after the accepting edge.
    task automatic watch_a(input string tag, input logic [63:0] blk, input int poke_at,
                           input logic [63:0] poke_data, input int rst_at,
                           input bit chain, input logic [63:0] chain_data);
        int          wave_err  = 0;
        int          busy_cnt  = 0;
        int          done_cnt  = 0;
        int          phase_err = 0;
        int          frame_err = 0;
        int          bad       = 0;
        logic [63:0] got       = '0;
        bit          seen[$];
        build_wave(blk, NB_A, CPB_A);
        for (int k = 0; k <= LEN_A; k++) begin
            bit exp_tx;
            exp_tx = (k < LEN_A) ? exp_wave[k] : 1'b1;
            if (a_tx !== exp_tx) wave_err++;
            if (a_busy === 1'b1) busy_cnt++;
            if (a_done === 1'b1) done_cnt++;
            if (a_busy !== (k < LEN_A) || a_done !== (k == LEN_A)) phase_err++;
            seen.push_back(a_tx);
            if (k == rst_at) begin
                a_start = 1'b0;
                rst     = 1'b1;
                step();
                rst = 1'b0;
                check({tag, "_tx"}, a_tx, 1);
                check({tag, "_busy"}, a_busy, 0);
                check({tag, "_done"}, a_done, 0);
                repeat (10) begin
                    step();
                    if (a_done !== 1'b0 || a_tx !== 1'b1 || a_busy !== 1'b0) bad++;
                end
                check({tag, "_quiet"}, bad, 0);
                return;
            end
            a_start = (k == poke_at) || (chain && k == LEN_A);
            if (k == poke_at)               a_data = poke_data;
            else if (chain && k == LEN_A)   a_data = chain_data;
            else                            a_data = {$urandom, $urandom};
            step();
        end
        a_start = 1'b0;
        for (int f = 0; f < NB_A; f++) begin
            int base;
            base = f * 10 * CPB_A + CPB_A / 2;
            if (seen[base] !== 1'b0 || seen[base + 9*CPB_A] !== 1'b1) frame_err++;
            for (int b = 0; b < 8; b++) got[f*8 + b] = seen[base + (b+1)*CPB_A];
            check($sformatf("%s_byte%0d", tag, f), got[f*8 +: 8], blk[f*8 +: 8]);
        end
        check({tag, "_first"}, seen[0], 0);
        check({tag, "_framing"}, frame_err, 0);
        check({tag, "_wave"}, wave_err, 0);
        check({tag, "_busy_len"}, busy_cnt, LEN_A);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_phase"}, phase_err, 0);
    endtask

    initial begin
        int          bad;
        logic [63:0] blk;
        logic [19:0] b_seq;
        int          b_busy_cnt;
        int          b_done_at;

        rst = 1'b1; a_start = 1'b0; a_data = '0; b_start = 1'b0; b_data = '0;

        bad = 0;
        repeat (5) begin
            step();
            if (a_tx !== 1'b1 || a_busy !== 1'b0 || a_done !== 1'b0) bad++;
            if (b_tx !== 1'b1 || b_busy !== 1'b0 || b_done !== 1'b0) bad++;
        end
        check("reset_vals", bad, 0);
        rst = 1'b0;
        bad = 0;
        repeat (200) begin
            a_data = {$urandom, $urandom};
            step();
            if (a_tx !== 1'b1 || a_busy !== 1'b0 || a_done !== 1'b0) bad++;
        end
        check("idle", bad, 0);

        blk = 64'h0123456789ABCDEF;
        start_a(blk);
        watch_a("basic", blk, -1, '0, -1, 1'b0, '0);

        start_a(blk);
        watch_a("busy_start", blk, 100, '1, -1, 1'b0, '0);

        blk = {$urandom, $urandom};
        start_a(blk);
        watch_a("chain_src", blk, -1, '0, -1, 1'b1, 64'h00000000000000A5);
        check("b2b_gap_tx", a_tx, 0);
        check("b2b_gap_busy", a_busy, 1);
        watch_a("b2b", 64'h00000000000000A5, -1, '0, -1, 1'b0, '0);

        // Byte 3 occupies samples 120..159; its data bits start at 124.
        blk = {$urandom, $urandom};
        start_a(blk);
        watch_a("rst_mid", blk, -1, '0, 130, 1'b0, '0);
        blk = {$urandom, $urandom};
        start_a(blk);
        watch_a("after_rst", blk, -1, '0, -1, 1'b0, '0);

        for (int i = 0; i < 3; i++) begin
            blk = {$urandom, $urandom};
            start_a(blk);
            watch_a($sformatf("rand%0d", i), blk, int'($urandom_range(1, LEN_A - 1)),
                    {$urandom, $urandom}, -1, 1'b0, '0);
        end

        b_data  = 8'h80;
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        build_wave(64'h80, NB_B, CPB_B);
        bad = 0; b_busy_cnt = 0; b_done_at = -1; b_seq = '0;
        for (int k = 0; k <= LEN_B; k++) begin
            if (k < LEN_B) begin
                b_seq[LEN_B - 1 - k] = b_tx;
                if (b_tx !== exp_wave[k]) bad++;
            end
            if (b_busy === 1'b1) b_busy_cnt++;
            if (b_done === 1'b1) b_done_at = k;
            b_data = 8'($urandom);
            step();
        end
        check("sweep_wave", bad, 0);
        check("sweep_seq", b_seq, 20'b0000_0000_0000_0000_1111);
        check("sweep_busy_len", b_busy_cnt, LEN_B);
        check("sweep_done_at", b_done_at, LEN_B);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
